fampiga_clkgen: RTL and testbench



---
 rtl/fampiga_clkgen_pkg.sv | 22 ++
 rtl/fampiga_clkgen_if.sv | 33 +++
 rtl/fampiga_clkgen_divider.sv | 58 +++++
 rtl/fampiga_clkgen.sv | 149 ++++++++++++++
 tb/tb_fampiga_clkgen.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fampiga_clkgen_pkg.sv
// -----------------------------------------------------------------------------
// fampiga_clk_pkg
// Shared constants and types for the Fampiga clock-enable / reset sequencer.
//   CLK7_CNT_INIT : 7 MHz phase counter value held while unlocked / in reset
//   ECLK_W        : width of the one-hot E-clock ring
//   ECLK_INIT     : E-clock ring value held while unlocked / in reset
//   clk7_phase_t  : 2-bit 7 MHz phase type
//   eclk_rotl     : one-step left rotation of the E-clock ring (MSB wraps to LSB)
// -----------------------------------------------------------------------------
package fampiga_clk_pkg;

    typedef logic [1:0] clk7_phase_t;

    localparam clk7_phase_t CLK7_CNT_INIT = 2'b10;
    localparam int          ECLK_W        = 10;
    localparam logic [ECLK_W-1:0] ECLK_INIT = 10'b0000000001;

    function automatic logic [ECLK_W-1:0] eclk_rotl(input logic [ECLK_W-1:0] v);
        return {v[ECLK_W-2:0], v[ECLK_W-1]};
    endfunction

endpackage

// File: rtl/fampiga_clkgen_if.sv
// -----------------------------------------------------------------------------
// fampiga_clkgen_if
// Bundle of every enable/level the clock sequencer hands to the core.
//   master : driven by fampiga_clkgen
//   slave  : consumed by the core (or a testbench)
// Signals: locked, rst_out_n, clk28_en, clk7_cnt, clk7, clk7_en, c1, c3,
//          cck, eclk[ECLK_W-1:0]
// -----------------------------------------------------------------------------
interface fampiga_clkgen_if;
    import fampiga_clk_pkg::*;

    logic              locked;
    logic              rst_out_n;
    logic              clk28_en;
    clk7_phase_t       clk7_cnt;
    logic              clk7;
    logic              clk7_en;
    logic              c1;
    logic              c3;
    logic              cck;
    logic [ECLK_W-1:0] eclk;

    modport master (
        output locked, rst_out_n, clk28_en, clk7_cnt, clk7, clk7_en,
               c1, c3, cck, eclk
    );

    modport slave (
        input  locked, rst_out_n, clk28_en, clk7_cnt, clk7, clk7_en,
               c1, c3, cck, eclk
    );

endinterface

// File: rtl/fampiga_clkgen_divider.sv
// -----------------------------------------------------------------------------
// fampiga_clk_divider
// Free-running modulo-DIV counter with a registered one-cycle pulse that is
// high in exactly the cycle where the count sits at DIV-1.
// Ports:
//   clk_i     : system clock
//   rst_n_i   : synchronous active-low reset
//   pulse_o   : one-cycle pulse per DIV clocks
// Parameter: DIV (2..16)
// -----------------------------------------------------------------------------
module fampiga_clk_divider #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic pulse_o
);

    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          pulse_d;

    // Next count and pulse; the pulse is decoded from the next count so the
    // registered pulse coincides with the count being at DIV-1.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        if (cnt_d == LAST) begin
            pulse_d = 1'b1;
        end else begin
            pulse_d = 1'b0;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/fampiga_clkgen.sv
// -----------------------------------------------------------------------------
// fampiga_clkgen
// Clock-enable and reset sequencer for the Fampiga core. Everything runs on
// the single system clock; no derived clocks are generated.
// Ports:
//   clk     : system clock (nominally 114 MHz)
//   reset_n : synchronous active-low reset
//   bus     : fampiga_clkgen_if.master - lock, core reset, 28/7/3.5 MHz
//             enables and levels, E-clock ring
// Parameters: DIV28 (2..16), LOCK_CYCLES (2..65535), RESET_HOLD (1..255)
// Build option: define FAMPIGA_ECLK_EN to instantiate the 10-phase E-clock
//   ring; without it eclk is tied to zero.
// -----------------------------------------------------------------------------
module fampiga_clkgen
    import fampiga_clk_pkg::*;
#(
    parameter int DIV28       = 4,
    parameter int LOCK_CYCLES = 1024,
    parameter int RESET_HOLD  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    fampiga_clkgen_if.master  bus
);

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(RESET_HOLD - 1);

    logic        clk28_en_s;
    logic        boundary_s;
    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic        locked_q,   locked_d;
    clk7_phase_t clk7_cnt_q, clk7_cnt_d;
    logic        clk7_en_q,  clk7_en_d;
    logic        cck_q,      cck_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        rst_out_q,  rst_out_d;

    fampiga_clk_divider #(.DIV(DIV28)) u_div28 (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .pulse_o (clk28_en_s)
    );

    // 7 MHz boundary: the last 28 MHz slot of a 7 MHz period while locked.
    assign boundary_s = clk28_en_s && locked_q && (clk7_cnt_q == 2'd3);

    // Next-state logic for lock, 7 MHz phase, colour clock and core reset.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        clk7_cnt_d = clk7_cnt_q;
        clk7_en_d  = clk7_en_q;
        cck_d      = cck_q;
        hold_cnt_d = hold_cnt_q;
        rst_out_d  = rst_out_q;

        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + 16'd1;
            if (lock_cnt_q == LOCK_LAST) begin
                locked_d = 1'b1;
            end else begin
                locked_d = 1'b0;
            end
        end else begin
            lock_cnt_d = lock_cnt_q;
        end

        // The phase uses the registered lock, so a lock edge coinciding with
        // a 28 MHz enable does not advance the phase in that cycle.
        if (!locked_q) begin
            clk7_cnt_d = CLK7_CNT_INIT;
            clk7_en_d  = 1'b1;
        end else if (clk28_en_s) begin
            clk7_cnt_d = clk7_cnt_q + 2'd1;
            clk7_en_d  = (clk7_cnt_q == 2'd0);
        end else begin
            clk7_cnt_d = clk7_cnt_q;
            clk7_en_d  = clk7_en_q;
        end

        if (boundary_s) begin
            cck_d = ~cck_q;
        end else begin
            cck_d = cck_q;
        end

        if (boundary_s && !rst_out_q) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            rst_out_d  = (hold_cnt_q == HOLD_LAST);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_cnt_q <= 16'd0;
            locked_q   <= 1'b0;
            clk7_cnt_q <= CLK7_CNT_INIT;
            clk7_en_q  <= 1'b1;
            cck_q      <= 1'b0;
            hold_cnt_q <= 8'd0;
            rst_out_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            clk7_cnt_q <= clk7_cnt_d;
            clk7_en_q  <= clk7_en_d;
            cck_q      <= cck_d;
            hold_cnt_q <= hold_cnt_d;
            rst_out_q  <= rst_out_d;
        end
    end

`ifdef FAMPIGA_ECLK_EN
    logic [ECLK_W-1:0] eclk_q;

    // E-clock ring: one step per 7 MHz boundary, held at its seed while unlocked.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            eclk_q <= ECLK_INIT;
        end else if (!locked_q) begin
            eclk_q <= ECLK_INIT;
        end else if (boundary_s) begin
            eclk_q <= eclk_rotl(eclk_q);
        end else begin
            eclk_q <= eclk_q;
        end
    end

    assign bus.eclk = eclk_q;
`else
    assign bus.eclk = '0;
`endif

    assign bus.locked    = locked_q;
    assign bus.rst_out_n = rst_out_q;
    assign bus.clk28_en  = clk28_en_s;
    assign bus.clk7_cnt  = clk7_cnt_q;
    assign bus.clk7_en   = clk7_en_q;
    assign bus.cck       = cck_q;
    // Level decodes of the phase counter.
    assign bus.clk7      = clk7_cnt_q[1];
    assign bus.c3        = clk7_cnt_q[1];
    assign bus.c1        = clk7_cnt_q[1] ^ clk7_cnt_q[0];

endmodule

// File: tb/tb_fampiga_clkgen.sv
// -----------------------------------------------------------------------------
// tb_fampiga_clkgen
// Randomised-reset bench for fampiga_clkgen with default parameters. The
// expected outputs are derived from the number of clock edges elapsed since
// the last reset, using closed-form arithmetic on the enable/phase rules.
// -----------------------------------------------------------------------------
module tb_fampiga_clkgen;

    localparam int D = 4;
    localparam int L = 1024;
    localparam int H = 16;

    typedef struct {
        logic       locked;
        logic       rst_out_n;
        logic       clk28_en;
        logic [1:0] cnt;
        logic       clk7;
        logic       clk7_en;
        logic       c1;
        logic       c3;
        logic       cck;
        logic [9:0] eclk;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   t;
    exp_t sb_q[$];

    fampiga_clkgen_if bus ();

    fampiga_clkgen #(.DIV28(D), .LOCK_CYCLES(L), .RESET_HOLD(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of 7 MHz boundaries passed after t edges out of reset.
    function automatic int phase_steps(input int te);
        if (te - 1 >= L) return te / D - L / D;
        return 0;
    endfunction

    function automatic int boundaries(input int te);
        return (phase_steps(te) + 2) / 4;
    endfunction

    function automatic exp_t model(input int te);
        exp_t e;
        int   n;
        int   b;
        n = phase_steps(te);
        b = boundaries(te);
        e.clk28_en  = (te > 0) && (te % D == D - 1);
        e.locked    = (te >= L);
        e.cnt       = 2'((2 + n) % 4);
        e.clk7_en   = (n == 0) ? 1'b1 : (e.cnt == 2'd1);
        e.clk7      = e.cnt[1];
        e.c3        = e.cnt[1];
        e.c1        = e.cnt[1] ^ e.cnt[0];
        e.cck       = (b % 2) == 1;
        e.rst_out_n = (b >= H);
`ifdef FAMPIGA_ECLK_EN
        e.eclk      = 10'(1 << (b % 10));
`else
        e.eclk      = 10'd0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            if (bad <= 50)
                $display("FAIL %s t=%0d got=0x%0h want=0x%0h", name, t, act, req);
        end
    endtask

    // Drive one edge's worth of reset and queue the post-edge expectation.
    task automatic step(input logic rn);
        @(negedge clk);
        reset_n = rn;
        if (rn) t = t + 1;
        else    t = 0;
        sb_q.push_back(model(t));
    endtask

    // Monitor: compare every post-edge output set against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("locked",    10'(bus.locked),    10'(e.locked));
                check("rst_out_n", 10'(bus.rst_out_n), 10'(e.rst_out_n));
                check("clk28_en",  10'(bus.clk28_en),  10'(e.clk28_en));
                check("clk7_cnt",  10'(bus.clk7_cnt),  10'(e.cnt));
                check("clk7",      10'(bus.clk7),      10'(e.clk7));
                check("clk7_en",   10'(bus.clk7_en),   10'(e.clk7_en));
                check("c1",        10'(bus.c1),        10'(e.c1));
                check("c3",        10'(bus.c3),        10'(e.c3));
                check("cck",       10'(bus.cck),       10'(e.cck));
                check("eclk",      bus.eclk,           e.eclk);
            end
        end
    end

    // Stimulus: reset, long run through lock and core reset release,
    // targeted mid-run reset, then randomised reset bursts.
    initial begin
        int guard;
        total   = 0;
        bad     = 0;
        t       = 0;
        reset_n = 1'b0;

        repeat (5) step(1'b0);
        repeat (2100) step(1'b1);

        // Reset for one cycle while the ring sits at phase 6.
        guard = 0;
        while (!((t >= L) && (boundaries(t) % 10 == 6)) && guard < 2000) begin
            step(1'b1);
            guard = guard + 1;
        end
        check("ring6_reach", 10'(guard < 2000), 10'd1);
        step(1'b0);
        repeat (1200) step(1'b1);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 3)) step(1'b0);
            repeat ($urandom_range(200, 1600)) begin
                step(($urandom_range(0, 511) == 0) ? 1'b0 : 1'b1);
            end
        end

        @(posedge clk);
        #2;
        check("queue_drained", 10'(sb_q.size()), 10'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
